// File: rtl/trb_read_streamer_pkg.sv
// Shared types and widths for the trace-buffer read path.
// Optional m_last sideband is enabled with TRB_STREAM_LAST_EN.
package trb_read_streamer_pkg;

    localparam int TRB_ADDR_WIDTH = 4;
    localparam int TRB_WIDTH      = 16;
    localparam int TRB_PTR_WIDTH  = TRB_ADDR_WIDTH + 1;

    typedef logic [TRB_PTR_WIDTH-1:0] trb_ptr_t;
    typedef logic [TRB_WIDTH-1:0]     trb_word_t;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } trb_rd_state_t;

endpackage

// File: rtl/trb_skid_buffer.sv
// 2-entry register FIFO; head register drives the outputs directly, push and pop may coincide.
// Latency 1 cycle push-to-head; caller must not push when full without popping. Macro TRB_STREAM_LAST_EN adds a last bit.
module trb_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
`ifdef TRB_STREAM_LAST_EN
    input  logic             push_last,
    output logic             head_last,
`endif
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occupancy
);

`ifdef TRB_STREAM_LAST_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [SW-1:0] head;
    logic [SW-1:0] tail;
    logic [SW-1:0] in_word;
    logic [1:0]    occ;

`ifdef TRB_STREAM_LAST_EN
    assign in_word   = {push_last, push_data};
    assign head_last = head[WIDTH];
`else
    assign in_word   = push_data;
`endif

    assign head_data  = head[WIDTH-1:0];
    assign head_valid = (occ != 2'd0);
    assign occupancy  = occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (clear) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= in_word;
                    else             tail <= in_word;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Full: the older tail word moves up, the new word queues behind it.
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= in_word;
                    end else begin
                        head <= in_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/trb_read_streamer.sv
// Drains trace-buffer BRAM words between rd_ptr and wr_ptr onto a valid/ready stream at 1 word/cycle.
// wr_ptr advance to m_valid is 2 cycles; with m_ready low at most 2 words are fetched. Macro TRB_STREAM_LAST_EN adds m_last.
module trb_read_streamer
    import trb_read_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
    parameter int DATA_WIDTH = TRB_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef TRB_STREAM_LAST_EN
    output logic                  m_last,
`endif
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    trb_rd_state_t       state;
    logic                inflight;
    logic [1:0]          occ;
    logic [ADDR_WIDTH:0] avail;
    logic [ADDR_WIDTH:0] ptr_next;
    logic [2:0]          pending;
    logic                pop;
    logic                push;
    logic                issue;

    assign avail    = wr_ptr - rd_ptr;
    assign ptr_next = rd_ptr + PTR_ONE;
    assign pop      = m_valid & m_ready;
    assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue    = enable & ~flush & (avail != '0) & (pending < 3'd2);
    // Data landing in the cycle after a flush belongs to the discarded window.
    assign push     = inflight & (state == ST_RUN);
    assign rd_addr  = rd_ptr[ADDR_WIDTH-1:0];
    assign empty    = (avail == '0) & ~inflight & (occ == 2'd0);

`ifdef TRB_STREAM_LAST_EN
    logic inflight_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            rd_ptr   <= '0;
            inflight <= 1'b0;
`ifdef TRB_STREAM_LAST_EN
            inflight_last <= 1'b0;
`endif
        end else if (flush) begin
            state    <= ST_FLUSH;
            rd_ptr   <= wr_ptr;
            inflight <= 1'b0;
        end else begin
            state    <= ST_RUN;
            inflight <= issue;
            if (issue) begin
                rd_ptr <= ptr_next;
`ifdef TRB_STREAM_LAST_EN
                inflight_last <= (ptr_next == wr_ptr);
`endif
            end
        end
    end

    trb_skid_buffer #(
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push       (push),
        .push_data  (rd_data),
`ifdef TRB_STREAM_LAST_EN
        .push_last  (inflight_last),
        .head_last  (m_last),
`endif
        .pop        (pop),
        .head_data  (m_data),
        .head_valid (m_valid),
        .occupancy  (occ)
    );

endmodule

// File: tb/tb_trb_read_streamer.sv
// Directed bench for trb_read_streamer with a behavioural 16-word BRAM; define TRB_STREAM_LAST_EN to also check m_last.
module tb_trb_read_streamer;
    import trb_read_streamer_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          empty;
`ifdef TRB_STREAM_LAST_EN
    logic          m_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trb_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .flush   (flush),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
`ifdef TRB_STREAM_LAST_EN
        .m_last  (m_last),
`endif
        .empty   (empty)
    );

    function automatic logic [DW-1:0] dw(input int a);
        return 16'hC000 + 16'(a % 16) * 16'd257;
    endfunction

    // Registered-read BRAM holding a fixed pattern per address.
    always @(posedge clk) rd_data <= dw(int'(rd_addr));

    typedef struct {
        logic [AW:0]   wr;
        logic          rdy;
        logic          en;
        logic          fl;
        logic [AW:0]   e_ptr;
        logic          e_vld;
        logic [DW-1:0] e_dat;
        logic          e_emp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int wr, input bit rdy, input bit en, input bit fl,
                                input int ptr, input bit vld, input logic [DW-1:0] dat, input bit emp);
        vec_t v;
        v.wr = 5'(wr); v.rdy = rdy; v.en = en; v.fl = fl;
        v.e_ptr = 5'(ptr); v.e_vld = vld; v.e_dat = dat; v.e_emp = emp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int ncyc, input int first, input int cnt, input int last_at, input string tag);
        int got = 0;
        m_ready = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (m_valid) begin
                if (got < cnt) chk($sformatf("%s word%0d data", tag, got), 32'(m_data), 32'(dw(first + got)));
`ifdef TRB_STREAM_LAST_EN
                chk($sformatf("%s word%0d last", tag, got), 32'(m_last), 32'(got == last_at));
`endif
                got++;
            end
            tick();
        end
        chk($sformatf("%s word count", tag), 32'(got), 32'(cnt));
    endtask

    initial begin
        // Burst of 4 from reset.
        tbl.push_back(mk( 0,1,1,0,  0,0,0,1));
        tbl.push_back(mk( 4,1,1,0,  0,0,0,0));
        tbl.push_back(mk( 4,1,1,0,  1,0,0,0));
        tbl.push_back(mk( 4,1,1,0,  2,1,dw(0),0));
        tbl.push_back(mk( 4,1,1,0,  3,1,dw(1),0));
        tbl.push_back(mk( 4,1,1,0,  4,1,dw(2),0));
        tbl.push_back(mk( 4,1,1,0,  4,1,dw(3),0));
        tbl.push_back(mk( 4,1,1,0,  4,0,0,1));
        // Stall with 8 available, then release.
        tbl.push_back(mk(12,0,1,0,  4,0,0,0));
        tbl.push_back(mk(12,0,1,0,  5,0,0,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(12,0,1,0, 6,1,dw(4),0));
        tbl.push_back(mk(12,1,1,0,  6,1,dw(4),0));
        for (int k = 6; k <= 12; k++) tbl.push_back(mk(12,1,1,0, (k < 12) ? k + 1 : 12, 1, dw(k - 1), 0));
        tbl.push_back(mk(12,1,1,0, 12,0,0,1));
        // Flush to 14, then wrap through address 0.
        tbl.push_back(mk(14,1,1,1, 12,0,0,0));
        tbl.push_back(mk(18,1,1,0, 14,0,0,0));
        tbl.push_back(mk(18,1,1,0, 15,0,0,0));
        tbl.push_back(mk(18,1,1,0, 16,1,dw(14),0));
        tbl.push_back(mk(18,1,1,0, 17,1,dw(15),0));
        tbl.push_back(mk(18,1,1,0, 18,1,dw(0),0));
        tbl.push_back(mk(18,1,1,0, 18,1,dw(1),0));
        tbl.push_back(mk(18,1,1,0, 18,0,0,1));

        reset = 1'b1; enable = 1'b1; flush = 1'b0; m_ready = 1'b1; wr_ptr = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset rd_ptr", 32'(rd_ptr), 0);
        chk("reset m_valid", 32'(m_valid), 0);
        chk("reset m_data", 32'(m_data), 0);
        chk("reset empty", 32'(empty), 1);
`ifdef TRB_STREAM_LAST_EN
        chk("reset m_last", 32'(m_last), 0);
`endif
        tick();
        reset = 1'b0;

        foreach (tbl[i]) begin
            wr_ptr = tbl[i].wr; m_ready = tbl[i].rdy; enable = tbl[i].en; flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("vec%0d rd_ptr", i), 32'(rd_ptr), 32'(tbl[i].e_ptr));
            chk($sformatf("vec%0d rd_addr", i), 32'(rd_addr), 32'(tbl[i].e_ptr[AW-1:0]));
            chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk($sformatf("vec%0d m_data", i), 32'(m_data), 32'(tbl[i].e_dat));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e_emp));
            tick();
        end
        flush = 1'b0;

        // Flush with one word buffered and one in flight.
        m_ready = 1'b0; wr_ptr = 5'd23;
        tick(); tick();
        flush = 1'b1; wr_ptr = 5'd25; m_ready = 1'b1;
        @(negedge clk);
        chk("flush pre m_valid", 32'(m_valid), 1);
        chk("flush pre m_data", 32'(m_data), 32'(dw(2)));
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush rd_ptr", 32'(rd_ptr), 25);
        chk("flush m_valid", 32'(m_valid), 0);
        chk("flush empty", 32'(empty), 1);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-flush m_valid c%0d", c), 32'(m_valid), 0);
            tick();
        end

        // Reset mid-stream.
        m_ready = 1'b0; wr_ptr = 5'd30;
        tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        chk("pre-reset m_valid", 32'(m_valid), 1);
        chk("pre-reset m_data", 32'(m_data), 32'(dw(9)));
        tick();
        @(negedge clk);
        chk("mid reset m_valid", 32'(m_valid), 0);
        chk("mid reset rd_ptr", 32'(rd_ptr), 0);
        chk("mid reset empty (wr=30)", 32'(empty), 0);
        wr_ptr = '0;
        #1;
        chk("mid reset empty (wr=0)", 32'(empty), 1);
        tick();
        reset = 1'b0; m_ready = 1'b1;

        // Enable low holds off issuing; words follow once enabled.
        enable = 1'b0; wr_ptr = 5'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("disabled rd_ptr c%0d", c), 32'(rd_ptr), 0);
            chk($sformatf("disabled m_valid c%0d", c), 32'(m_valid), 0);
            chk($sformatf("disabled empty c%0d", c), 32'(empty), 0);
            tick();
        end
        enable = 1'b1;
        drain(8, 0, 3, 2, "enable");
        @(negedge clk);
        chk("enable rd_ptr", 32'(rd_ptr), 3);
        chk("enable empty", 32'(empty), 1);
        tick();

        // Single-word step: marked last.
        wr_ptr = 5'd4;
        drain(5, 3, 1, 0, "single");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
